// File: rtl/i2c_slave_regfile.sv
// I2C slave with byte-addressed register port, fully clocked on CLCK.
// Define I2C_GCALL_EN to ACK general call (8'h00) writes starting at register 0.
`timescale 1ns/1ps
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h12,
  parameter int NUM_REGS = 16,
  parameter int FILTER_LEN = 3,
  localparam int PW = $clog2(NUM_REGS)
) (
  input  logic          CLCK,
  input  logic          rst_n,
  input  logic          SCL,
  inout  wire           SDA,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          rd_req,
  output logic [PW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy,
  output logic          flag
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] FMAX = CW'(FILTER_LEN - 1);

  logic [1:0]    s0, s1, filt, filt_d;
  logic [CW-1:0] fcnt [2];

  state_t        state, state_n;
  logic [2:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          oe, oe_n;
  logic          busy_n, wr_en_n, rd_req_n, flag_n;
  logic [PW-1:0] wr_addr_n;
  logic [7:0]    wr_data_n;
  logic          rw, rw_n, gc, gc_n;

  logic scl_rise, scl_fall, start, stop;
  logic [7:0] byte_in;

  // Index 1 carries SCL, index 0 carries SDA.
  // Synchronise both pins, then move the filtered level only after a full run of agreeing samples.
  always_ff @(posedge CLCK or negedge rst_n) begin
    if (!rst_n) begin
      s0     <= '1;
      s1     <= '1;
      filt   <= '1;
      filt_d <= '1;
      fcnt   <= '{default: '0};
    end else begin
      s0     <= {SCL, SDA};
      s1     <= s0;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s1[i] != filt[i]) begin
          if (fcnt[i] == FMAX) begin
            filt[i] <= s1[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign scl_rise = filt[1] & ~filt_d[1];
  assign scl_fall = ~filt[1] & filt_d[1];
  assign start    = ~filt[0] & filt_d[0] & filt[1] & filt_d[1];
  assign stop     = filt[0] & ~filt_d[0] & filt[1] & filt_d[1];
  assign byte_in  = {sh[6:0], filt[0]};

  assign SDA     = oe ? 1'b0 : 1'bz;
  assign rd_addr = ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_REGS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Register the FSM state together with the shift, pointer and strobe outputs.
  always_ff @(posedge CLCK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sh      <= '0;
      ptr     <= '0;
      oe      <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_req  <= 1'b0;
      flag    <= 1'b0;
      rw      <= 1'b0;
      gc      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh      <= sh_n;
      ptr     <= ptr_n;
      oe      <= oe_n;
      busy    <= busy_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      rd_req  <= rd_req_n;
      flag    <= flag_n;
      rw      <= rw_n;
      gc      <= gc_n;
    end
  end

  // Bus conditions win over bit sampling; SDA is updated on the cycle after scl_fall.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_n      = sh;
    ptr_n     = ptr;
    oe_n      = oe;
    busy_n    = busy;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rd_req_n  = 1'b0;
    flag_n    = 1'b0;
    rw_n      = rw;
    gc_n      = gc;
    if (rd_req) sh_n = rd_data;
    if (start) begin
      state_n = ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      oe_n    = 1'b0;
    end else if (scl_fall) begin
      unique case (state)
        ADDR_ACK, PTR_ACK, WDATA_ACK: oe_n = 1'b1;
        RDATA:                        oe_n = ~sh[7];
        default:                      oe_n = 1'b0;
      endcase
    end else if (scl_rise) begin
      unique case (state)
        ADDR: begin
          sh_n  = byte_in;
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7) begin
            gc_n = 1'b0;
            rw_n = byte_in[0];
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
`ifdef I2C_GCALL_EN
            end else if (byte_in == 8'h00) begin
              state_n = ADDR_ACK;
              busy_n  = 1'b1;
              gc_n    = 1'b1;
`endif
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          cnt_n = '0;
          if (rw) begin
            state_n  = RDATA;
            rd_req_n = 1'b1;
          end else if (gc) begin
            state_n = WDATA;
            ptr_n   = '0;
          end else begin
            state_n = PTR;
          end
        end
        PTR: begin
          sh_n  = byte_in;
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7) begin
            if (int'(byte_in) < NUM_REGS) begin
              state_n = PTR_ACK;
              ptr_n   = byte_in[PW-1:0];
            end else begin
              state_n = IGNORE;
              busy_n  = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          state_n = WDATA;
          cnt_n   = '0;
        end
        WDATA: begin
          sh_n  = byte_in;
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7) begin
            state_n   = WDATA_ACK;
            wr_en_n   = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = byte_in;
            ptr_n     = nxt(ptr);
          end
        end
        RDATA: begin
          sh_n  = byte_in;
          cnt_n = cnt + 1'b1;
          if (cnt == 3'd7) state_n = RDATA_ACK;
        end
        RDATA_ACK: begin
          flag_n = 1'b1;
          cnt_n  = '0;
          if (!filt[0]) begin
            state_n  = RDATA;
            ptr_n    = nxt(ptr);
            rd_req_n = 1'b1;
          end else begin
            state_n = IGNORE;
            busy_n  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: table-driven write vectors, directed read/glitch/reset
// sequences and a randomized transaction run against a pointer/register model.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

  localparam int Q = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic       wr_en, rd_req, busy, flag;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign rd_data = 8'h80 ^ {4'h0, rd_addr};

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .CLCK    (clk),
    .rst_n   (rst_n),
    .SCL     (m_scl),
    .SDA     (sda),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .flag    (flag)
  );

  logic [11:0] wlog [1024];
  int wcnt = 0;
  int fcnt = 0;
  int rcnt = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wlog[wcnt % 1024] <= {wr_addr, wr_data};
      wcnt <= wcnt + 1;
    end
    if (flag) fcnt <= fcnt + 1;
    if (rd_req) rcnt <= rcnt + 1;
  end

  int ncmp = 0;
  int nbad = 0;
  int wrd = 0;
  logic [11:0] expq [$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bitx(input logic b, input int gl, output logic r);
    m_sda_low = !b;
    wt(Q/2);
    if (gl == 1) begin
      m_scl = 1'b1;
      @(negedge clk);
      m_scl = 1'b0;
    end
    wt(Q/2);
    m_scl = 1'b1;
    wt(Q/2);
    r = sda;
    if (gl == 2) begin
      m_sda_low = !m_sda_low;
      @(negedge clk);
      m_sda_low = !m_sda_low;
    end
    wt(Q/2);
    m_scl = 1'b0;
    wt(Q/2);
  endtask

  task automatic wbyte(input logic [7:0] d, input bit gl, output logic ack);
    logic r;
    int g;
    for (int i = 7; i >= 0; i--) begin
      g = !gl ? 0 : (i == 5) ? 1 : (i == 2 || i == 1) ? 2 : 0;
      bitx(d[i], g, r);
    end
    bitx(1'b1, 0, r);
    ack = !r;
  endtask

  task automatic rbyte(input logic last, output logic [7:0] d);
    logic r;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      bitx(1'b1, 0, r);
      d = {d[6:0], r};
    end
    bitx(last, 0, r);
  endtask

  task automatic start_c();
    m_sda_low = 1'b0;
    wt(Q);
    m_scl = 1'b1;
    wt(Q);
    m_sda_low = 1'b1;
    wt(Q);
    m_scl = 1'b0;
    wt(Q/2);
  endtask

  task automatic stop_c();
    m_sda_low = 1'b1;
    wt(Q);
    m_scl = 1'b1;
    wt(Q);
    m_sda_low = 1'b0;
    wt(Q);
  endtask

  task automatic check_writes();
    wt(4);
    chk("wr_count", wcnt - wrd, expq.size());
    while (expq.size() > 0 && wrd < wcnt) begin
      chk("wr_entry", wlog[wrd % 1024], expq.pop_front());
      wrd++;
    end
    expq.delete();
    wrd = wcnt;
  endtask

  typedef struct {
    logic [3:0][7:0]  b;
    int               nb;
    logic [3:0]       ack;
    int               nw;
    logic [1:0][11:0] w;
  } vec_t;

  vec_t tv [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic a;
    logic r;
    logic [7:0] d;
    int f0, r0, mptr, op, p, n;

    tv[0] = '{b: {8'h5A, 8'hA5, 8'h03, 8'h24}, nb: 4, ack: 4'b1111,
              nw: 2, w: {12'h45A, 12'h3A5}};
    tv[1] = '{b: {8'h22, 8'h11, 8'h0F, 8'h24}, nb: 4, ack: 4'b1111,
              nw: 2, w: {12'h022, 12'hF11}};
    tv[2] = '{b: {8'h00, 8'h55, 8'h03, 8'h26}, nb: 3, ack: 4'b0000,
              nw: 0, w: '0};
    tv[3] = '{b: {8'h00, 8'h00, 8'h20, 8'h24}, nb: 2, ack: 4'b0001,
              nw: 0, w: '0};
    tv[4] = '{b: {8'h00, 8'h00, 8'h10, 8'h24}, nb: 2, ack: 4'b0001,
              nw: 0, w: '0};
`ifdef I2C_GCALL_EN
    tv[5] = '{b: {8'h00, 8'h00, 8'h77, 8'h00}, nb: 2, ack: 4'b0011,
              nw: 1, w: {12'h000, 12'h077}};
`else
    tv[5] = '{b: {8'h00, 8'h00, 8'h77, 8'h00}, nb: 2, ack: 4'b0000,
              nw: 0, w: '0};
`endif

    wt(4);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_flag", flag, 0);
    chk("rst_ptr", rd_addr, 0);
    rst_n = 1'b1;
    wt(8);

    for (int k = 0; k < 6; k++) begin
      r0 = rcnt;
      start_c();
      for (int i = 0; i < tv[k].nb; i++) begin
        wbyte(tv[k].b[i], 1'b0, a);
        chk($sformatf("v%0d_ack%0d", k, i), a, tv[k].ack[i]);
        if (i == 0) chk($sformatf("v%0d_busy", k), busy, tv[k].ack[0]);
        if (!a) begin
          chk($sformatf("v%0d_busy_nack", k), busy, 0);
          break;
        end
      end
      stop_c();
      chk($sformatf("v%0d_busy_stop", k), busy, 0);
      chk($sformatf("v%0d_rd_req", k), rcnt - r0, 0);
      for (int j = 0; j < tv[k].nw; j++) expq.push_back(tv[k].w[j]);
      check_writes();
    end

    start_c();
    wbyte(8'h24, 1'b0, a);
    chk("sr_addw_ack", a, 1);
    wbyte(8'h05, 1'b0, a);
    chk("sr_ptr_ack", a, 1);
    start_c();
    f0 = fcnt;
    r0 = rcnt;
    wbyte(8'h25, 1'b0, a);
    chk("sr_addr_ack", a, 1);
    rbyte(1'b0, d);
    chk("sr_rd0", d, 8'h85);
    rbyte(1'b0, d);
    chk("sr_rd1", d, 8'h86);
    rbyte(1'b1, d);
    chk("sr_rd2", d, 8'h87);
    wt(4);
    chk("sr_sda_rel", sda, 1);
    chk("sr_busy", busy, 0);
    stop_c();
    chk("sr_flags", fcnt - f0, 3);
    chk("sr_rd_reqs", rcnt - r0, 3);
    check_writes();

    start_c();
    wbyte(8'h24, 1'b1, a);
    chk("gl_addr_ack", a, 1);
    wbyte(8'h07, 1'b1, a);
    chk("gl_ptr_ack", a, 1);
    wbyte(8'h3C, 1'b1, a);
    chk("gl_data_ack", a, 1);
    stop_c();
    expq.push_back(12'h73C);
    check_writes();

    start_c();
    wbyte(8'h24, 1'b0, a);
    wbyte(8'h05, 1'b0, a);
    start_c();
    wbyte(8'h25, 1'b0, a);
    chk("mr_addr_ack", a, 1);
    bitx(1'b1, 0, r);
    chk("mr_bit7", r, 1);
    wt(4);
    chk("mr_sda_driven", sda, 0);
    chk("mr_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_sda_rel", sda, 1);
    chk("mr_busy0", busy, 0);
    chk("mr_wr_en0", wr_en, 0);
    chk("mr_rd_req0", rd_req, 0);
    chk("mr_flag0", flag, 0);
    chk("mr_ptr0", rd_addr, 0);
    wt(3);
    rst_n = 1'b1;
    wt(4);
    stop_c();
    start_c();
    wbyte(8'h25, 1'b0, a);
    chk("pr_addr_ack", a, 1);
    rbyte(1'b1, d);
    chk("pr_rd", d, 8'h80);
    stop_c();
    check_writes();

    mptr = 0;
    repeat (16) begin
      op = $urandom_range(0, 2);
      p = 0;
      if (op != 1) begin
        p = (op == 0) ? $urandom_range(0, 19) : $urandom_range(0, 15);
        start_c();
        wbyte(8'h24, 1'b0, a);
        chk("rnd_addw_ack", a, 1);
        wbyte(p[7:0], 1'b0, a);
        chk("rnd_ptr_ack", a, p < 16);
        if (p < 16) mptr = p;
        if (op == 0 && p < 16) begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            wbyte(d, 1'b0, a);
            chk("rnd_wd_ack", a, 1);
            expq.push_back({4'(mptr), d});
            mptr = (mptr + 1) % 16;
          end
        end
      end
      if (op != 0) begin
        start_c();
        f0 = fcnt;
        wbyte(8'h25, 1'b0, a);
        chk("rnd_addr_ack", a, 1);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          rbyte(i == n - 1, d);
          chk("rnd_rd", d, 8'h80 ^ 8'(mptr));
          if (i < n - 1) mptr = (mptr + 1) % 16;
        end
        stop_c();
        chk("rnd_flags", fcnt - f0, n);
      end else begin
        stop_c();
      end
      check_writes();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
